scan_capture: RTL and testbench

SCAN_CAPTURE -- requirements
Module: scan_capture

---
 rtl/scan_capture.sv | 226 ++++++++++++++++++++++
 tb/tb_scan_capture.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_capture.sv
// Rebuilds a 4-digit frame by sampling a multiplexed 7-segment display bus.
// Define SCAN_CAPTURE_DP_EN to capture and report the decimal points.
module scan_capture #(
    parameter int STABLE_CYC = 4,
    parameter int FRAME_TO   = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  select,
    input  logic [6:0]  seg_in,
    input  logic        dp_in,
    output logic [15:0] digits,
    output logic [3:0]  dp_flags,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        sel_err
);

`ifdef SCAN_CAPTURE_DP_EN
    localparam int IW = 12;
`else
    localparam int IW = 11;
`endif
    localparam logic [IW-1:0] SYNC_RST = {4'hF, {(IW-4){1'b0}}};

    typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_HOLD} state_t;

    logic [1:0]    r_rst_sync;
    logic          w_rst_n;
    logic [IW-1:0] w_in;
    logic [IW-1:0] r_sync1;
    logic [IW-1:0] r_sync2;
    logic [IW-1:0] r_prev;
    logic          w_chg;
    logic [3:0]    w_sel;
    logic [6:0]    w_seg;
    logic [3:0]    w_val;
    logic          w_seg_ok;
    logic [1:0]    w_idx;
    logic          w_sel_ok;
    logic          w_take;
    logic          w_valid;
    logic [3:0]    w_seen_nxt;
    logic [15:0]   w_shadow_nxt;
    state_t        r_state;
    logic [7:0]    r_cnt;
    logic [15:0]   r_to_cnt;
    logic [3:0]    r_seen;
    logic [15:0]   r_shadow;
    logic [15:0]   r_digits;
    logic          r_frame_valid;
    logic          r_seg_err;
    logic          r_sel_err;

    // Assert asynchronously, release only after two clean clock edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

`ifdef SCAN_CAPTURE_DP_EN
    assign w_in = {select, seg_in, dp_in};
`else
    assign w_in = {select, seg_in};
`endif

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sync1 <= SYNC_RST;
            r_sync2 <= SYNC_RST;
            r_prev  <= SYNC_RST;
        end else begin
            r_sync1 <= w_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_chg = (r_sync2 != r_prev);
    assign w_sel = r_sync2[IW-1 -: 4];
    assign w_seg = r_sync2[IW-5 -: 7];

    always_comb begin
        w_val    = 4'h0;
        w_seg_ok = 1'b1;
        case (w_seg)
            7'h7E:   w_val = 4'h0;
            7'h30:   w_val = 4'h1;
            7'h6D:   w_val = 4'h2;
            7'h79:   w_val = 4'h3;
            7'h33:   w_val = 4'h4;
            7'h5B:   w_val = 4'h5;
            7'h5F:   w_val = 4'h6;
            7'h70:   w_val = 4'h7;
            7'h7F:   w_val = 4'h8;
            7'h7B:   w_val = 4'h9;
            7'h77:   w_val = 4'hA;
            7'h1F:   w_val = 4'hB;
            7'h4E:   w_val = 4'hC;
            7'h3D:   w_val = 4'hD;
            7'h4F:   w_val = 4'hE;
            7'h47:   w_val = 4'hF;
            7'h00:   w_val = 4'h0;
            default: w_seg_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_idx    = 2'd0;
        w_sel_ok = 1'b1;
        case (w_sel)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_sel_ok = 1'b0;
        endcase
    end

    // Counter reaches STABLE_CYC-1 on this cycle's increment
    assign w_take  = (r_state == S_SETTLE) && !w_chg
                   && (r_cnt == 8'(STABLE_CYC - 2));
    assign w_valid = w_take && w_sel_ok && w_seg_ok;
    assign w_seen_nxt = r_seen | (4'b0001 << w_idx);

    always_comb begin
        w_shadow_nxt = r_shadow;
        w_shadow_nxt[{w_idx, 2'b00} +: 4] = w_val;
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_WAIT;
            r_cnt   <= 8'd0;
        end else begin
            unique case (r_state)
                S_WAIT, S_HOLD: begin
                    if (w_chg) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= 8'd0;
                    end
                end
                S_SETTLE: begin
                    if (w_chg) begin
                        r_cnt <= 8'd0;
                    end else if (w_take) begin
                        r_state <= S_HOLD;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= S_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_to_cnt      <= 16'd0;
            r_seen        <= 4'd0;
            r_shadow      <= 16'd0;
            r_digits      <= 16'd0;
            r_frame_valid <= 1'b0;
            r_seg_err     <= 1'b0;
            r_sel_err     <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_seg_err     <= 1'b0;
            r_sel_err     <= 1'b0;
            if (w_take && !w_sel_ok)
                r_sel_err <= 1'b1;
            else if (w_take && !w_seg_ok)
                r_seg_err <= 1'b1;
            if (w_valid) begin
                r_to_cnt <= 16'd0;
                r_shadow <= w_shadow_nxt;
                if (&w_seen_nxt) begin
                    r_seen        <= 4'd0;
                    r_digits      <= w_shadow_nxt;
                    r_frame_valid <= 1'b1;
                end else begin
                    r_seen <= w_seen_nxt;
                end
            end else if (r_to_cnt == 16'(FRAME_TO - 1)) begin
                r_to_cnt <= 16'(FRAME_TO);
                r_seen   <= 4'd0;
            end else if (r_to_cnt != 16'(FRAME_TO)) begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end
        end
    end

`ifdef SCAN_CAPTURE_DP_EN
    logic [3:0] r_dp_sh;
    logic [3:0] r_dp_flags;
    logic [3:0] w_dp_nxt;

    always_comb begin
        w_dp_nxt        = r_dp_sh;
        w_dp_nxt[w_idx] = r_sync2[0];
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_dp_sh    <= 4'd0;
            r_dp_flags <= 4'd0;
        end else if (w_valid) begin
            r_dp_sh <= w_dp_nxt;
            if (&w_seen_nxt) r_dp_flags <= w_dp_nxt;
        end
    end
    assign dp_flags = r_dp_flags;
`else
    logic w_unused_dp;
    assign w_unused_dp = dp_in;
    assign dp_flags    = 4'b0000;
`endif

    assign digits      = r_digits;
    assign frame_valid = r_frame_valid;
    assign seg_err     = r_seg_err;
    assign sel_err     = r_sel_err;

endmodule

// File: tb/tb_scan_capture.sv
// Randomized and directed bench for scan_capture against a frame-level model.
// Honours SCAN_CAPTURE_DP_EN for the expected decimal-point flags.
module tb_scan_capture;

    localparam int ST = 4;
    localparam int FT = 256;
`ifdef SCAN_CAPTURE_DP_EN
    localparam bit DP_ON = 1'b1;
`else
    localparam bit DP_ON = 1'b0;
`endif
    localparam logic [6:0] PAT [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  select;
    logic [6:0]  seg_in;
    logic        dp_in;
    logic [15:0] digits;
    logic [3:0]  dp_flags;
    logic        frame_valid;
    logic        seg_err;
    logic        sel_err;

    always #5 clk = ~clk;

    scan_capture #(.STABLE_CYC(ST), .FRAME_TO(FT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .select      (select),
        .seg_in      (seg_in),
        .dp_in       (dp_in),
        .digits      (digits),
        .dp_flags    (dp_flags),
        .frame_valid (frame_valid),
        .seg_err     (seg_err),
        .sel_err     (sel_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame-level reference model
    int          m_val [4];
    bit          m_dp [4];
    bit          m_seen [4];
    logic [15:0] m_digits = 16'h0;
    logic [3:0]  m_dpf = 4'h0;
    int          m_frames = 0;
    int          m_seg = 0;
    int          m_sel = 0;

    function automatic int decode(input logic [6:0] s);
        if (s == 7'h00) return 0;
        for (int k = 0; k < 16; k++)
            if (PAT[k] == s) return k;
        return -1;
    endfunction

    function automatic logic [3:0] sel_of(input int i);
        logic [3:0] m;
        m = 4'b1111;
        m[i] = 1'b0;
        return m;
    endfunction

    function automatic int sel_index(input logic [3:0] s);
        for (int k = 0; k < 4; k++)
            if (s == sel_of(k)) return k;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_val[k] = 0;
            m_dp[k] = 1'b0;
            m_seen[k] = 1'b0;
        end
        m_digits = 16'h0;
        m_dpf = 4'h0;
    endtask

    task automatic model_timeout();
        for (int k = 0; k < 4; k++) m_seen[k] = 1'b0;
    endtask

    task automatic model_sample(input logic [3:0] s, input logic [6:0] g,
                                input bit d);
        int i;
        int v;
        i = sel_index(s);
        v = decode(g);
        if (i < 0) m_sel++;
        else if (v < 0) m_seg++;
        else begin
            m_val[i] = v;
            m_dp[i] = d;
            m_seen[i] = 1'b1;
            if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
                m_digits = 16'h0;
                m_dpf = 4'h0;
                for (int k = 0; k < 4; k++) begin
                    m_digits = m_digits | (16'(m_val[k]) << (4 * k));
                    if (DP_ON && m_dp[k]) m_dpf[k] = 1'b1;
                    m_seen[k] = 1'b0;
                end
                m_frames++;
            end
        end
    endtask

    // Pulse monitor
    int o_frames = 0;
    int o_seg = 0;
    int o_sel = 0;
    int o_viol = 0;
    bit q_fv = 1'b0;
    bit q_se = 1'b0;
    bit q_le = 1'b0;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) o_frames++;
        if (seg_err === 1'b1) o_seg++;
        if (sel_err === 1'b1) o_sel++;
        if (int'(frame_valid === 1'b1) + int'(seg_err === 1'b1)
            + int'(sel_err === 1'b1) > 1) o_viol++;
        if ((frame_valid === 1'b1 && q_fv) || (seg_err === 1'b1 && q_se)
            || (sel_err === 1'b1 && q_le)) o_viol++;
        q_fv = (frame_valid === 1'b1);
        q_se = (seg_err === 1'b1);
        q_le = (sel_err === 1'b1);
    end

    logic [3:0] p_sel = 4'hF;
    logic [6:0] p_seg = 7'h00;

    task automatic check_all(input string tag);
        check({tag, ".frames"}, o_frames, m_frames);
        check({tag, ".seg_err"}, o_seg, m_seg);
        check({tag, ".sel_err"}, o_sel, m_sel);
        check({tag, ".digits"}, digits, m_digits);
        check({tag, ".dp_flags"}, dp_flags, m_dpf);
    endtask

    // Long holds (>= ST+4) yield exactly one sample; holds of 1..2 none
    task automatic step(input string tag, input logic [3:0] s,
                        input logic [6:0] g, input bit d, input int hold);
        @(negedge clk);
        select = s;
        seg_in = g;
        dp_in = d;
        p_sel = s;
        p_seg = g;
        repeat (hold - 1) @(negedge clk);
        if (hold >= ST + 4) begin
            model_sample(s, g, d);
            #1;
            check_all(tag);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        select = 4'hF;
        seg_in = 7'h00;
        dp_in = 1'b0;
        p_sel = 4'hF;
        p_seg = 7'h00;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("rst.digits", digits, 16'h0);
        check("rst.dp_flags", dp_flags, 4'h0);
        check("rst.pulses", {frame_valid, seg_err, sel_err}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    logic [3:0] r_s;
    logic [6:0] r_g;
    bit         r_d;
    int         r_h;
    int         r_r;
    int         run;
    int         f0;

    initial begin
        rst_n = 1'b0;
        select = 4'hF;
        seg_in = 7'h00;
        dp_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("por.digits", digits, 16'h0);
        check("por.pulses", {frame_valid, seg_err, sel_err}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Plain scan of 1,2,3,4
        for (int i = 0; i < 4; i++)
            step("scan", sel_of(i), PAT[i + 1], 1'b0, 20);
        check("scan.value", digits, 16'h4321);
        check("scan.count", o_frames, 1);

        // Undecodable pattern on digit 2
        step("seg0", sel_of(0), 7'h7E, 1'b0, 12);
        step("seg1", sel_of(1), 7'h30, 1'b0, 12);
        step("seg3", sel_of(3), 7'h79, 1'b0, 12);
        step("segbad", sel_of(2), 7'h01, 1'b0, 12);
        step("seg2", sel_of(2), 7'h6D, 1'b0, 12);
        check("seg.value", digits, 16'h3210);

        // Non one-hot select between digits
        step("sel0", sel_of(0), 7'h4F, 1'b0, 12);
        step("selbad", 4'b0011, 7'h4F, 1'b0, 10);
        step("sel1", sel_of(1), 7'h47, 1'b0, 12);
        step("sel2", sel_of(2), 7'h77, 1'b0, 12);
        step("sel3", sel_of(3), 7'h1F, 1'b0, 12);
        check("sel.value", digits, 16'hBAFE);

        // Glitching segments on digit 3
        step("gl0", sel_of(0), 7'h5F, 1'b0, 12);
        step("gl1", sel_of(1), 7'h70, 1'b0, 12);
        step("gl2", sel_of(2), 7'h7F, 1'b0, 12);
        f0 = o_frames;
        for (int k = 0; k < 20; k++)
            step("glitch", sel_of(3), PAT[k % 16], 1'b0, 2);
        check("glitch.early", o_frames + o_seg + o_sel,
              f0 + m_seg + m_sel);
        step("gl3", sel_of(3), 7'h7B, 1'b0, 12);
        check("glitch.value", digits, 16'h9876);
        check("glitch.count", o_frames, f0 + 1);

        // Decimal point on digit 1 only
        for (int i = 0; i < 4; i++)
            step("dp", sel_of(i), PAT[5 + i], (i == 1), 12);
        check("dp.flags", dp_flags, DP_ON ? 4'b0010 : 4'b0000);
        check("dp.value", digits, 16'h8765);

        // Frame timeout after three digits
        step("to0", sel_of(0), PAT[1], 1'b0, 12);
        step("to1", sel_of(1), PAT[2], 1'b0, 12);
        step("to2", sel_of(2), PAT[3], 1'b0, 12);
        repeat (FT + 40) @(negedge clk);
        model_timeout();
        f0 = o_frames;
        step("to3", sel_of(3), PAT[4], 1'b0, 12);
        check("to.noframe", o_frames, f0);
        for (int i = 0; i < 4; i++)
            step("tofresh", sel_of(i), PAT[5 + i], 1'b0, 12);
        check("to.fresh", o_frames, f0 + 1);
        check("to.value", digits, 16'h4765);

        // Reset in the middle of a frame
        step("mr0", sel_of(0), PAT[9], 1'b0, 12);
        step("mr1", sel_of(1), PAT[10], 1'b0, 12);
        do_reset();
        f0 = o_frames;
        step("pr2", sel_of(2), PAT[10], 1'b0, 12);
        step("pr3", sel_of(3), PAT[11], 1'b0, 12);
        step("pr0", sel_of(0), PAT[12], 1'b0, 12);
        check("rst.partial", o_frames, f0);
        step("pr1", sel_of(1), PAT[13], 1'b0, 12);
        check("rst.fresh", o_frames, f0 + 1);
        check("rst.value", digits, 16'hBADC);

        // Random traffic; keeps valid samples well inside FRAME_TO
        run = 0;
        for (int n = 0; n < 150; n++) begin
            do begin
                r_r = $urandom_range(0, 9);
                if (r_r < 7 || run >= 5) r_s = sel_of($urandom_range(0, 3));
                else r_s = 4'($urandom);
                r_r = $urandom_range(0, 9);
                if (r_r < 6 || run >= 5) r_g = PAT[$urandom_range(0, 15)];
                else if (r_r < 7) r_g = 7'h00;
                else r_g = 7'($urandom);
            end while ({r_s, r_g} == {p_sel, p_seg});
            r_d = 1'($urandom);
            if ($urandom_range(0, 4) == 0 && run < 5) r_h = $urandom_range(1, 2);
            else r_h = $urandom_range(8, 20);
            if (r_h >= 8 && sel_index(r_s) >= 0 && decode(r_g) >= 0) run = 0;
            else run++;
            step("rand", r_s, r_g, r_d, r_h);
        end

        repeat (4) @(negedge clk);
        #1;
        check("pulse_rules", o_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
